// File: rtl/giu_drain_serializer.sv
// Drain stage for the GIU packing FIFO: accepts a contiguous prefix of up to
// six lane entries per cycle into a circular store and emits them one per cycle.
module giu_drain_serializer #(
  parameter int DATA_W = 80,
  parameter int LANES  = 6,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              test_en,
  input  logic              in_0_valid,
  output logic              in_0_ready,
  input  logic [DATA_W-1:0] in_0_data,
  input  logic              in_1_valid,
  output logic              in_1_ready,
  input  logic [DATA_W-1:0] in_1_data,
  input  logic              in_2_valid,
  output logic              in_2_ready,
  input  logic [DATA_W-1:0] in_2_data,
  input  logic              in_3_valid,
  output logic              in_3_ready,
  input  logic [DATA_W-1:0] in_3_data,
  input  logic              in_4_valid,
  output logic              in_4_ready,
  input  logic [DATA_W-1:0] in_4_data,
  input  logic              in_5_valid,
  output logic              in_5_ready,
  input  logic [DATA_W-1:0] in_5_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [LANES-1:0]  lane_valid;
  logic [LANES-1:0]  lane_ready;
  logic [DATA_W-1:0] lane_data [LANES];

  logic [DATA_W-1:0] store [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     n_acc;
  logic [CW:0]       space;
  logic              en;
  logic              pop;
  logic              hole;
  logic              stop;
  logic              unused_test_en;

  assign unused_test_en = test_en;

  assign lane_valid = {in_5_valid, in_4_valid, in_3_valid, in_2_valid, in_1_valid, in_0_valid};
  assign lane_data[0] = in_0_data;
  assign lane_data[1] = in_1_data;
  assign lane_data[2] = in_2_data;
  assign lane_data[3] = in_3_data;
  assign lane_data[4] = in_4_data;
  assign lane_data[5] = in_5_data;
  assign {in_5_ready, in_4_ready, in_3_ready, in_2_ready, in_1_ready, in_0_ready} = lane_ready;

  // Readiness depends only on registered occupancy, so a same-cycle pop never frees space.
  assign space = (CW+1)'(DEPTH) - {1'b0, count};

  for (genvar k = 0; k < LANES; k++) begin : g_rdy
    assign lane_ready[k] = en & (space > (CW+1)'(k));
  end

  always_comb begin
    n_acc = '0;
    stop  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!stop && lane_valid[k] && lane_ready[k]) n_acc = n_acc + CW'(1);
      else stop = 1'b1;
    end
  end

  always_comb begin
    hole = 1'b0;
    for (int k = 1; k < LANES; k++) begin
      if (lane_valid[k] && !lane_valid[k-1]) hole = 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = store[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) store[k] <= '0;
    end else begin
      en <= 1'b1;
      for (int k = 0; k < LANES; k++) begin
        if (CW'(k) < n_acc) store[wr_ptr + PW'(k)] <= lane_data[k];
      end
      wr_ptr <= wr_ptr + PW'(n_acc);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + n_acc - CW'(pop);
      if (en && hole) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_giu_drain_serializer.sv
// Scoreboard bench: a queue-based occupancy model predicts acceptance,
// readiness and err; a monitor pops and compares each emitted entry.
module tb_giu_drain_serializer;

  localparam int DW = 80;
  localparam int L  = 6;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          test_en;
  logic [L-1:0]  vld;
  logic [DW-1:0] dat [L];
  logic [L-1:0]  rdy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          err;

  logic [DW-1:0] exp_q [$];
  int            occ;
  bit            en_mdl;
  bit            err_mdl;
  int            checks;
  int            failures;
  int            pops_seen;
  int            lead;
  int            n_mdl;
  logic [L-1:0]  exp_rdy;

  always #5 clk = ~clk;

  giu_drain_serializer #(.DATA_W(DW), .LANES(L), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .test_en(test_en),
    .in_0_valid(vld[0]), .in_0_ready(rdy[0]), .in_0_data(dat[0]),
    .in_1_valid(vld[1]), .in_1_ready(rdy[1]), .in_1_data(dat[1]),
    .in_2_valid(vld[2]), .in_2_ready(rdy[2]), .in_2_data(dat[2]),
    .in_3_valid(vld[3]), .in_3_ready(rdy[3]), .in_3_data(dat[3]),
    .in_4_valid(vld[4]), .in_4_ready(rdy[4]), .in_4_data(dat[4]),
    .in_5_valid(vld[5]), .in_5_ready(rdy[5]), .in_5_data(dat[5]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom});
  endfunction

  always @(negedge reset_n) begin
    exp_q.delete();
    occ     = 0;
    en_mdl  = 1'b0;
    err_mdl = 1'b0;
  end

  // Predictor: the store accepts min(valid prefix, free slots) once enabled.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_ready", DW'(rdy), '0);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_err", DW'(err), '0);
    end else begin
      exp_rdy = '0;
      for (int k = 0; k < L; k++) if (en_mdl && (D - occ) > k) exp_rdy[k] = 1'b1;
      chk("ready", DW'(rdy), DW'(exp_rdy));
      chk("out_valid", DW'(out_valid), DW'(occ != 0));
      chk("err", DW'(err), DW'(err_mdl));
      lead = 0;
      while (lead < L && vld[lead]) lead++;
      n_mdl = !en_mdl ? 0 : (lead < D - occ) ? lead : D - occ;
      for (int k = 0; k < n_mdl; k++) exp_q.push_back(dat[k]);
      if (en_mdl) for (int k = 1; k < L; k++) if (vld[k] && !vld[k-1]) err_mdl = 1'b1;
      occ    = occ + n_mdl - ((out_ready && occ != 0) ? 1 : 0);
      en_mdl = 1'b1;
    end
  end

  // Monitor: every presented head must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stale_output actual=%h required=none", out_data);
      end else begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops_seen++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    int waited;
    checks = 0; failures = 0; pops_seen = 0;
    test_en = 1'b0;
    out_ready = 1'b0;
    reset_n = 1'b0;
    vld = '1;
    for (int k = 0; k < L; k++) dat[k] = rnd_data();

    // reset release with all lanes valid
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    vld = '0;
    step();

    // full burst 1..6
    out_ready = 1'b1;
    vld = '1;
    for (int k = 0; k < L; k++) dat[k] = DW'(k + 1);
    step();
    vld = '0;
    repeat (8) step();

    // fill: A0..A5 then B0..B5, only B0/B1 fit
    out_ready = 1'b0;
    vld = '1;
    for (int k = 0; k < L; k++) dat[k] = DW'(8'hA0 + k);
    step();
    for (int k = 0; k < L; k++) dat[k] = DW'(8'hB0 + k);
    step();
    vld = '0;
    chk("fill_ready_none", DW'(rdy), '0);
    chk("fill_head_a0", out_data, DW'(8'hA0));
    step();
    out_ready = 1'b1;
    repeat (12) step();

    // lane hole on lane 2
    vld = 6'b001011;
    dat[0] = DW'(8'h10); dat[1] = DW'(8'h11); dat[2] = DW'(8'h12); dat[3] = DW'(8'h13);
    step();
    vld = '0;
    repeat (4) step();
    chk("hole_err_sticky", DW'(err), DW'(1));

    // reset mid-stream with five buffered entries
    out_ready = 1'b0;
    vld = 6'b011111;
    for (int k = 0; k < L; k++) dat[k] = rnd_data();
    step();
    vld = '0;
    step();
    chk("pre_rst_valid", DW'(out_valid), DW'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", DW'(out_valid), '0);
    chk("rst_async_err", DW'(err), '0);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();

    // random soak
    for (int c = 0; c < 10000; c++) begin
      nv = $urandom_range(0, L);
      vld = L'((1 << nv) - 1);
      for (int k = 0; k < L; k++) dat[k] = rnd_data();
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    vld = '0;
    out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      step();
      waited++;
    end
    chk("drain_left", DW'(exp_q.size()), '0);
    step();
    chk("drain_out_valid", DW'(out_valid), '0);
    chk("soak_err", DW'(err), '0);
    chk("pops_many", DW'(pops_seen > 1000), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/giu_drain_serializer.md
# giu_drain_serializer

Downstream drain stage for the GIU multi-lane packing FIFO. Accepts up to six in-order entries per cycle from its pop lanes, which arrive as a contiguous prefix (lane 0 first). Buffers the entries in a small circular store and re-emits them as a single 80-bit valid/ready stream in exact arrival order. Also flags lane-contiguity violations on the input side.

## Interface
Parameters:
- DATA_W, 80, entry width
- LANES, 6, input lane count
- DEPTH, 8, staging entries; power of two, must be >= LANES

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  reset; **one clock; reset is asynchronous and active-low**
- test_en  input  1  scan/test enable; no functional effect
- in_k_valid  input  1  lane k entry present, k = 0..LANES-1
- in_k_ready  output  1  lane k may be accepted this cycle
- in_k_data  input  DATA_W  lane k entry; lane 0 is the oldest
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts the head
- out_data  output  DATA_W  head entry
- err  output  1  sticky lane-hole error

## Operation
- Storage:
  - buf[DEPTH] of DATA_W.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is clog2(DEPTH+1) bits.
- Ready generation is purely from registered state:
  - in_k_ready = en & ((DEPTH - count) > k).
  - A pop in the same cycle never frees space for that cycle's input.
- en flop:
  - Resets to 0; set to 1 on the first rising edge after reset_n deasserts.
  - All in_k_ready stay 0 while en = 0.
- Accept count n = number of leading lanes k (from 0 upward) with in_k_valid & in_k_ready. Stop at the first lane failing either term.
- Write: for each k < n, buf[(wr_ptr + k) mod DEPTH] <= in_k_data. Then wr_ptr <= wr_ptr + n (mod DEPTH).
- Lanes above a hole are not accepted, even if valid and ready. Upstream must hold them.
- Output side:
  - out_valid = (count != 0).
  - out_data = buf[rd_ptr].
  - Pop when out_valid & out_ready; rd_ptr <= rd_ptr + 1 on pop.
- count_next = count + n - pop. Simultaneous push and pop are legal in every state, including count = DEPTH (pop only) and count = 0 (push only).
- Order guarantee: out emits entries in order of (acceptance cycle, lane index).
- err:
  - Set when any in_k_valid = 1 with in_(k-1)_valid = 0, for k >= 1.
  - Checked every cycle while en = 1. Cleared only by reset.
  - No effect on datapath.

## Timing
- Reset values (asynchronous, immediate on reset_n low):
  - in_k_ready = 0, out_valid = 0, out_data = 0, err = 0.
  - count = 0, wr_ptr = 0, rd_ptr = 0, en = 0, buf cleared to 0.
- Reset mid-operation discards all buffered entries. No output handshake completes in the reset cycle.
- Latency: an entry accepted at edge N is visible on out_valid/out_data after edge N (cycle N+1) if it is the head. No combinational input-to-output path.
- Throughput:
  - Input: up to LANES entries per cycle.
  - Output: 1 entry per cycle.
- Sustained all-ready operation settles to in_0_ready only (steady state count >= DEPTH-1).
- out_valid/out_data remain stable while out_valid & !out_ready.
- in_k_ready may deassert without a handshake. Upstream must not drop valid entries because of that.

## Test plan
- **Reset release:** hold reset_n low 3 cycles with all in_k_valid = 1.
  - Expect in_k_ready = 0, out_valid = 0, err = 0 throughout.
  - Expect in_k_ready = 6'b111111 from the first cycle after the first post-release edge.
- **Full burst:** in lanes 0..5 valid with data 1..6 for one cycle, out_ready = 1.
  - Expect out_data 1,2,3,4,5,6 on six consecutive cycles starting the next cycle.
  - Expect the cycle after the burst to show in_0/in_1 ready only.
- **Fill:** out_ready = 0; offer 6 entries (A0..A5), then 6 more (B0..B5).
  - Expect A0..A5 and B0..B1 accepted, count = 8, all in_k_ready = 0.
  - Then raise out_ready: expect in_0_ready to return the cycle after the first pop, and output A0..A5, B0, B1, ... in order.
- **Lane hole:** valids on lanes 0, 1, 3 with data 0x10, 0x11, 0x13.
  - Expect only 0x10 and 0x11 accepted and err = 1, held sticky.
- **Reset mid-stream:** with count = 5, pulse reset_n low between edges.
  - Expect out_valid to drop immediately and count = 0.
  - Expect no stale data emitted after release.
- **Random soak:** 10k cycles of random prefix valids, random out_ready, scoreboard check.
  - Expect zero loss, zero reordering, pointers wrapped many times, err = 0.
